// File: rtl/acq_trigger_sequencer.sv
// Acquisition trigger sequencer: arm, optional pre-gate, counted start events, optional post-gate,
// then acquire until stop count, RAM full, abort or wait timeout. Optional macro: ACQ_HOLDOFF_EN.
module acq_trigger_sequencer #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_W   = 16
) (
  input  logic               CLK_MASTER,
  input  logic               RESET_N,
  input  logic               CKE_TICK,
  input  logic               START,
  input  logic               ABORT,
  input  logic [NUM_EVT-1:0] EVT_IN,
  input  logic [NUM_EVT-1:0] START_MASK,
  input  logic               START_ALWAYS,
  input  logic [NUM_EVT-1:0] STOP_MASK,
  input  logic [CNT_W-1:0]   START_NUM,
  input  logic [CNT_W-1:0]   STOP_NUM,
  input  logic               PRE_GATE_EN,
  input  logic               POST_GATE_EN,
  input  logic               GATE_PRE,
  input  logic               GATE_POST,
  input  logic [TMO_W-1:0]   TIMEOUT,
  input  logic               SR_R_FULL,
`ifdef ACQ_HOLDOFF_EN
  input  logic [TMO_W-1:0]   HOLDOFF,
`endif
  output logic               WAITING,
  output logic               ACQUIRING,
  output logic               DONE,
  output logic [2:0]         STOP_REASON
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_GATE  = 3'd1,
    S_WAIT      = 3'd2,
    S_POST_GATE = 3'd3,
    S_ACQ       = 3'd4
  } state_t;

  localparam logic [2:0] RSN_NONE    = 3'd0;
  localparam logic [2:0] RSN_STOP    = 3'd1;
  localparam logic [2:0] RSN_FULL    = 3'd2;
  localparam logic [2:0] RSN_ABORT   = 3'd3;
  localparam logic [2:0] RSN_TIMEOUT = 3'd4;

  state_t             state, state_nxt;
  logic [NUM_EVT-1:0] evt_prev, start_mask_q, stop_mask_q;
  logic               start_always_q, post_gate_q;
  logic [CNT_W-1:0]   scount, ecount;
  logic [TMO_W-1:0]   timeout_q, tick_cnt;
  logic               arm, set_reason, scount_dec, ecount_dec, busy, tmo_hit, stop_ok;
  logic [2:0]         reason_nxt;
  logic [NUM_EVT-1:0] evt_rise;
  logic               start_hit, stop_hit;

  assign evt_rise  = EVT_IN & ~evt_prev;
  assign start_hit = (|(evt_rise & start_mask_q)) | start_always_q;
  assign stop_hit  = |(evt_rise & stop_mask_q);
  assign busy      = state inside {S_PRE_GATE, S_WAIT, S_POST_GATE, S_ACQ};
  assign tmo_hit   = (timeout_q != '0) && (tick_cnt == timeout_q);

`ifdef ACQ_HOLDOFF_EN
  // Stop events are masked until HOLDOFF ticks have elapsed in ACQ; zero disables the holdoff.
  logic [TMO_W-1:0] holdoff_q, hold_cnt;
  assign stop_ok = (hold_cnt >= holdoff_q);

  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      holdoff_q <= '0;
      hold_cnt  <= '0;
    end else begin
      if (arm) holdoff_q <= HOLDOFF;
      if (state != S_ACQ)                   hold_cnt <= '0;
      else if (CKE_TICK && hold_cnt != '1) hold_cnt <= hold_cnt + TMO_W'(1);
    end
  end
`else
  assign stop_ok = 1'b1;
`endif

  // Next-state and sequencing decisions.
  always_comb begin
    state_nxt  = state;
    arm        = 1'b0;
    set_reason = 1'b0;
    reason_nxt = RSN_NONE;
    scount_dec = 1'b0;
    ecount_dec = 1'b0;
    case (state)
      S_IDLE: begin
        if (START && !ABORT) begin
          arm       = 1'b1;
          state_nxt = PRE_GATE_EN ? S_PRE_GATE : S_WAIT;
        end
      end
      S_PRE_GATE: begin
        if (tmo_hit) begin
          state_nxt  = S_IDLE;
          set_reason = 1'b1;
          reason_nxt = RSN_TIMEOUT;
        end else if (GATE_PRE) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmo_hit) begin
          state_nxt  = S_IDLE;
          set_reason = 1'b1;
          reason_nxt = RSN_TIMEOUT;
        end else if (start_hit) begin
          if (scount != '0) scount_dec = 1'b1;
          else              state_nxt  = post_gate_q ? S_POST_GATE : S_ACQ;
        end
      end
      S_POST_GATE: begin
        if (GATE_POST) state_nxt = S_ACQ;
      end
      S_ACQ: begin
        if (SR_R_FULL) begin
          state_nxt  = S_IDLE;
          set_reason = 1'b1;
          reason_nxt = RSN_FULL;
        end else if (stop_hit && stop_ok) begin
          if (ecount != '0) begin
            ecount_dec = 1'b1;
          end else begin
            state_nxt  = S_IDLE;
            set_reason = 1'b1;
            reason_nxt = RSN_STOP;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides everything in any legal busy state.
    if (busy && ABORT) begin
      state_nxt  = S_IDLE;
      set_reason = 1'b1;
      reason_nxt = RSN_ABORT;
      scount_dec = 1'b0;
      ecount_dec = 1'b0;
    end
  end

  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      evt_prev       <= '0;
      start_mask_q   <= '0;
      stop_mask_q    <= '0;
      start_always_q <= 1'b0;
      post_gate_q    <= 1'b0;
      scount         <= '0;
      ecount         <= '0;
      timeout_q      <= '0;
      tick_cnt       <= '0;
      WAITING        <= 1'b0;
      ACQUIRING      <= 1'b0;
      DONE           <= 1'b0;
      STOP_REASON    <= RSN_NONE;
    end else begin
      state     <= state_nxt;
      evt_prev  <= EVT_IN;
      WAITING   <= state_nxt inside {S_PRE_GATE, S_WAIT};
      ACQUIRING <= state_nxt inside {S_POST_GATE, S_ACQ};
      DONE      <= set_reason;
      if (arm) begin
        start_mask_q   <= START_MASK;
        stop_mask_q    <= STOP_MASK;
        start_always_q <= START_ALWAYS;
        post_gate_q    <= POST_GATE_EN;
        scount         <= START_NUM;
        ecount         <= STOP_NUM;
        timeout_q      <= TIMEOUT;
        tick_cnt       <= '0;
        STOP_REASON    <= RSN_NONE;
      end else begin
        if (scount_dec) scount <= scount - CNT_W'(1);
        if (ecount_dec) ecount <= ecount - CNT_W'(1);
        if (set_reason) STOP_REASON <= reason_nxt;
        // Tick counter runs only in the wait states and saturates.
        if (CKE_TICK && (state inside {S_PRE_GATE, S_WAIT}) && tick_cnt != '1)
          tick_cnt <= tick_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// Directed bench for acq_trigger_sequencer; expected stop reasons are queued and checked on each DONE.
module tb_acq_trigger_sequencer;
  localparam int unsigned NUM_EVT = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TMO_W   = 16;

  logic               clk, rst_n, cke, start, abort, start_always, pre_en, post_en;
  logic               gate_pre, gate_post, sr_full;
  logic [NUM_EVT-1:0] evt, smask, stmask;
  logic [CNT_W-1:0]   snum, stnum;
  logic [TMO_W-1:0]   timeout;
  logic               waiting, acquiring, done;
  logic [2:0]         reason;
`ifdef ACQ_HOLDOFF_EN
  logic [TMO_W-1:0]   holdoff;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [2:0]  exp_q[$];

  acq_trigger_sequencer #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .CLK_MASTER(clk), .RESET_N(rst_n), .CKE_TICK(cke), .START(start), .ABORT(abort),
    .EVT_IN(evt), .START_MASK(smask), .START_ALWAYS(start_always), .STOP_MASK(stmask),
    .START_NUM(snum), .STOP_NUM(stnum), .PRE_GATE_EN(pre_en), .POST_GATE_EN(post_en),
    .GATE_PRE(gate_pre), .GATE_POST(gate_post), .TIMEOUT(timeout), .SR_R_FULL(sr_full),
`ifdef ACQ_HOLDOFF_EN
    .HOLDOFF(holdoff),
`endif
    .WAITING(waiting), .ACQUIRING(acquiring), .DONE(done), .STOP_REASON(reason)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest queued stop reason.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got DONE with reason %0d, expected no DONE", reason);
      end else begin
        chk("stop_reason", 32'(reason), 32'(exp_q.pop_front()));
        chk("idle_on_done", {30'd0, waiting, acquiring}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse(input int b);
    evt[b] = 1'b1;
    tick();
    evt[b] = 1'b0;
    tick();
  endtask

  task automatic cke_pulse();
    cke = 1'b1;
    tick();
    cke = 1'b0;
    tick();
  endtask

  task automatic cfg_clear();
    smask = '0; stmask = '0; snum = '0; stnum = '0; timeout = '0;
    start_always = 1'b0; pre_en = 1'b0; post_en = 1'b0;
`ifdef ACQ_HOLDOFF_EN
    holdoff = '0;
`endif
  endtask

  initial begin
    rst_n = 1'b0; cke = 1'b0; start = 1'b0; abort = 1'b0; evt = '0;
    gate_pre = 1'b0; gate_post = 1'b0; sr_full = 1'b0;
    cfg_clear();
    ticks(2);
    chk("rst_waiting", 32'(waiting), 32'd0);
    chk("rst_acquiring", 32'(acquiring), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reason", 32'(reason), 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // Counted start (skip 2) and counted stop (skip 1) on EVT_IN[0].
    smask = 4'b0001; snum = 8'd2; stmask = 4'b0001; stnum = 8'd1;
    arm();
    chk("t1_waiting", 32'(waiting), 32'd1);
    pulse(0);
    pulse(0);
    chk("t1_no_acq_after_2", 32'(acquiring), 32'd0);
    evt[0] = 1'b1;
    tick();
    chk("t1_acq_after_3", 32'(acquiring), 32'd1);
    chk("t1_not_waiting", 32'(waiting), 32'd0);
    evt[0] = 1'b0;
    tick();
    exp_q.push_back(3'd1);
    pulse(0);
    chk("t1_acq_after_stop1", 32'(acquiring), 32'd1);
    pulse(0);
    chk("t1_idle", 32'(acquiring), 32'd0);
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_reason_held", 32'(reason), 32'd1);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    // A held event counts once: START_NUM=1 stays waiting through a 10-cycle level.
    cfg_clear();
    smask = 4'b0001; snum = 8'd1; stmask = 4'b0010;
    arm();
    chk("t2_reason_cleared", 32'(reason), 32'd0);
    evt[0] = 1'b1;
    ticks(10);
    chk("t2_still_waiting", 32'(waiting), 32'd1);
    chk("t2_no_acq", 32'(acquiring), 32'd0);
    evt[0] = 1'b0;
    tick();
    evt[0] = 1'b1;
    tick();
    chk("t2_acq_on_second_edge", 32'(acquiring), 32'd1);
    evt[0] = 1'b0;
    tick();
    exp_q.push_back(3'd1);
    pulse(1);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // Pre-gate blocks start events; RAM full beats a same-cycle final stop event.
    cfg_clear();
    pre_en = 1'b1; smask = 4'b0001; stmask = 4'b0001;
    arm();
    chk("t3_pre_waiting", 32'(waiting), 32'd1);
    pulse(0);
    chk("t3_event_ignored", 32'(acquiring), 32'd0);
    gate_pre = 1'b1;
    tick();
    gate_pre = 1'b0;
    chk("t3_wait_after_gate", 32'(waiting), 32'd1);
    pulse(0);
    chk("t3_acq", 32'(acquiring), 32'd1);
    exp_q.push_back(3'd2);
    sr_full = 1'b1;
    evt[0] = 1'b1;
    tick();
    sr_full = 1'b0;
    evt[0] = 1'b0;
    chk("t3_idle", 32'(acquiring), 32'd0);
    tick();
    chk("t3_pending", 32'(exp_q.size()), 32'd0);

    // Timeout after 3 ticks with no events.
    cfg_clear();
    timeout = 16'd3;
    arm();
    exp_q.push_back(3'd4);
    cke_pulse();
    cke_pulse();
    chk("t4_waiting_2ticks", 32'(waiting), 32'd1);
    cke = 1'b1;
    tick();
    cke = 1'b0;
    chk("t4_waiting_at_3", 32'(waiting), 32'd1);
    tick();
    chk("t4_idle", 32'(waiting), 32'd0);
    chk("t4_reason", 32'(reason), 32'd4);
    tick();
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // Abort in POST_GATE, then abort in IDLE and abort blocking START.
    cfg_clear();
    post_en = 1'b1; smask = 4'b0001;
    arm();
    pulse(0);
    chk("t5_postgate_acq", 32'(acquiring), 32'd1);
    chk("t5_postgate_not_wait", 32'(waiting), 32'd0);
    exp_q.push_back(3'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_idle", 32'(acquiring), 32'd0);
    chk("t5_abort_reason", 32'(reason), 32'd3);
    tick();
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("t5_idle_abort_reason", 32'(reason), 32'd3);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("t5_abort_blocks_start", 32'(waiting), 32'd0);
    tick();

    // Asynchronous reset mid-ACQ clears outputs immediately.
    cfg_clear();
    smask = 4'b0001;
    arm();
    pulse(0);
    chk("t6_acq", 32'(acquiring), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_acq", 32'(acquiring), 32'd0);
    chk("t6_rst_wait", 32'(waiting), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_reason", 32'(reason), 32'd0);
    tick();
    rst_n = 1'b1;
    ticks(2);
    chk("t6_idle_after", 32'(waiting), 32'd0);
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
